vc_alloc_ctrl: RTL and testbench

- Allocation, write-back and flush sequencer for the 4-way dcache victim-cache tag store.
- Accepts victim-line insert requests from the dcache eviction path and picks a way: first invalid way, otherwise tree-PLRU.
- Before overwriting a dirty way, requests a write-back; then drives the tag store's write and clear ports.
- Also runs a full flush: write back all dirty valid ways, then clear everything.

---
 rtl/vc_alloc_ctrl.sv | 183 ++++++++++++++++++
 tb/tb_vc_alloc_ctrl.sv | 354 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vc_alloc_ctrl.sv
// Victim-cache allocation, write-back and flush sequencer for a 4-way tag store.
// Picks a victim (first invalid way, else tree-PLRU) and evicts dirty lines before overwrite.
module vc_alloc_ctrl #(
  parameter int AWT         = 32,
  parameter int WORD_SEL    = 4,
  parameter int TAG_WT_VC   = AWT - WORD_SEL - 2,
  parameter int VC_WAYS_EXP = 2,
  parameter int VC_WAYS     = 2**VC_WAYS_EXP
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   ins_req_i,
  input  logic [TAG_WT_VC-1:0]   ins_tag_i,
  input  logic                   ins_dirty_i,
  output logic                   ins_ack_o,
  output logic [VC_WAYS_EXP-1:0] ins_way_o,
  input  logic                   acc_en_i,
  input  logic [VC_WAYS_EXP-1:0] acc_way_i,
  input  logic                   acc_st_i,
  input  logic                   flush_req_i,
  output logic                   flush_done_o,
  input  logic [VC_WAYS-1:0]     valid_i,
  output logic                   wb_req_o,
  output logic [VC_WAYS_EXP-1:0] wb_way_o,
  input  logic                   wb_ack_i,
  output logic                   wr_en_o,
  output logic [VC_WAYS_EXP-1:0] wr_way_o,
  output logic [TAG_WT_VC-1:0]   wr_tag_o,
  output logic                   clear_line_o,
  output logic [VC_WAYS_EXP-1:0] clear_way_o,
  output logic                   clear_all_o,
  output logic                   busy_o
);

  typedef enum logic [2:0] {
    IDLE,
    EV_WB,
    WRITE,
    FL_SCAN,
    FL_WB,
    FL_CLR,
    FL_DONE
  } state_e;

  state_e                 state_q, state_d;
  logic [VC_WAYS-1:0]     dirty_q, dirty_d;
  logic [2:0]             plru_q, plru_d;
  logic [VC_WAYS_EXP-1:0] way_q, way_d;
  logic [TAG_WT_VC-1:0]   tag_q, tag_d;
  logic [VC_WAYS_EXP-1:0] victim;
  logic                   wayDirty;
  logic                   lastWay;

  function automatic logic [2:0] plruTouch(input logic [2:0] p,
                                           input logic [VC_WAYS_EXP-1:0] w);
    logic [2:0] n;
    n    = p;
    n[0] = ~w[1];
    if (w[1]) n[2] = ~w[0];
    else      n[1] = ~w[0];
    return n;
  endfunction

  // Lowest invalid way overrides the PLRU tree walk.
  always_comb begin
    victim = plru_q[0] ? {1'b1, plru_q[2]} : {1'b0, plru_q[1]};
    for (int i = VC_WAYS - 1; i >= 0; i--) begin
      if (!valid_i[i]) victim = VC_WAYS_EXP'(i);
    end
  end

  // way_q holds the latched victim during an insert and the scan index during a flush.
  assign wayDirty = valid_i[way_q] && dirty_q[way_q];
  assign lastWay  = (way_q == VC_WAYS_EXP'(VC_WAYS - 1));

  always_comb begin
    state_d      = state_q;
    dirty_d      = dirty_q;
    plru_d       = plru_q;
    way_d        = way_q;
    tag_d        = tag_q;
    ins_ack_o    = 1'b0;
    ins_way_o    = '0;
    wb_req_o     = 1'b0;
    wb_way_o     = '0;
    wr_en_o      = 1'b0;
    wr_way_o     = '0;
    wr_tag_o     = '0;
    clear_all_o  = 1'b0;
    flush_done_o = 1'b0;

    // Hits update first so that the controller's own updates below take precedence.
    if (acc_en_i) begin
      plru_d = plruTouch(plru_q, acc_way_i);
      if (acc_st_i) dirty_d[acc_way_i] = 1'b1;
    end

    case (state_q)
      IDLE: begin
        if (flush_req_i) begin
          way_d   = '0;
          state_d = FL_SCAN;
        end else if (ins_req_i) begin
          way_d   = victim;
          tag_d   = ins_tag_i;
          state_d = (valid_i[victim] && dirty_q[victim]) ? EV_WB : WRITE;
        end
      end
      EV_WB: begin
        wb_req_o = 1'b1;
        wb_way_o = way_q;
        if (wb_ack_i) begin
          dirty_d[way_q] = 1'b0;
          state_d        = WRITE;
        end
      end
      WRITE: begin
        wr_en_o        = 1'b1;
        wr_way_o       = way_q;
        wr_tag_o       = tag_q;
        ins_ack_o      = 1'b1;
        ins_way_o      = way_q;
        dirty_d[way_q] = ins_dirty_i;
        plru_d         = plruTouch(plru_d, way_q);
        state_d        = IDLE;
      end
      FL_SCAN: begin
        if (wayDirty) begin
          state_d = FL_WB;
        end else if (lastWay) begin
          state_d = FL_CLR;
        end else begin
          way_d = way_q + VC_WAYS_EXP'(1);
        end
      end
      FL_WB: begin
        wb_req_o = 1'b1;
        wb_way_o = way_q;
        if (wb_ack_i) begin
          dirty_d[way_q] = 1'b0;
          if (lastWay) begin
            state_d = FL_CLR;
          end else begin
            way_d   = way_q + VC_WAYS_EXP'(1);
            state_d = FL_SCAN;
          end
        end
      end
      FL_CLR: begin
        clear_all_o = 1'b1;
        dirty_d     = '0;
        state_d     = FL_DONE;
      end
      FL_DONE: begin
        flush_done_o = 1'b1;
        state_d      = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= IDLE;
      dirty_q <= '0;
      plru_q  <= '0;
      way_q   <= '0;
      tag_q   <= '0;
    end else begin
      state_q <= state_d;
      dirty_q <= dirty_d;
      plru_q  <= plru_d;
      way_q   <= way_d;
      tag_q   <= tag_d;
    end
  end

  // Targeted invalidate is reserved; the port is tied off.
  assign clear_line_o = 1'b0;
  assign clear_way_o  = '0;
  assign busy_o       = (state_q != IDLE);

endmodule

// File: tb/tb_vc_alloc_ctrl.sv
// Self-checking bench for vc_alloc_ctrl: directed vector table, multi-cycle corner
// sequences and a randomized run against a transaction-level model of the allocator.
module tb_vc_alloc_ctrl;
  localparam int TW = 26;

  logic          clk_i       = 1'b0;
  logic          rst_i       = 1'b0;
  logic          ins_req_i   = 1'b0;
  logic [TW-1:0] ins_tag_i   = '0;
  logic          ins_dirty_i = 1'b0;
  logic          ins_ack_o;
  logic [1:0]    ins_way_o;
  logic          acc_en_i    = 1'b0;
  logic [1:0]    acc_way_i   = '0;
  logic          acc_st_i    = 1'b0;
  logic          flush_req_i = 1'b0;
  logic          flush_done_o;
  logic [3:0]    valid_i;
  logic          wb_req_o;
  logic [1:0]    wb_way_o;
  logic          wb_ack_i    = 1'b0;
  logic          wr_en_o;
  logic [1:0]    wr_way_o;
  logic [TW-1:0] wr_tag_o;
  logic          clear_line_o;
  logic [1:0]    clear_way_o;
  logic          clear_all_o;
  logic          busy_o;

  int testsRun    = 0;
  int testsFailed = 0;

  bit refValid[4];
  bit refDirty[4];
  bit refTree[3];

  logic [3:0] tagValid;

  typedef enum int {OP_INS, OP_ACC, OP_FLUSH} op_e;
  typedef struct {
    op_e op;
    int  arg;
    bit  flag;
    int  delay;
    int  expWay;
    bit  expWb;
    int  expWbCount;
  } vec_t;

  always #5 clk_i = ~clk_i;

  vc_alloc_ctrl dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .ins_req_i    (ins_req_i),
    .ins_tag_i    (ins_tag_i),
    .ins_dirty_i  (ins_dirty_i),
    .ins_ack_o    (ins_ack_o),
    .ins_way_o    (ins_way_o),
    .acc_en_i     (acc_en_i),
    .acc_way_i    (acc_way_i),
    .acc_st_i     (acc_st_i),
    .flush_req_i  (flush_req_i),
    .flush_done_o (flush_done_o),
    .valid_i      (valid_i),
    .wb_req_o     (wb_req_o),
    .wb_way_o     (wb_way_o),
    .wb_ack_i     (wb_ack_i),
    .wr_en_o      (wr_en_o),
    .wr_way_o     (wr_way_o),
    .wr_tag_o     (wr_tag_o),
    .clear_line_o (clear_line_o),
    .clear_way_o  (clear_way_o),
    .clear_all_o  (clear_all_o),
    .busy_o       (busy_o)
  );

  // Stand-in for the tag store's valid bits, driven by the controller's write/clear ports.
  always @(posedge clk_i or negedge rst_i) begin
    if (!rst_i)           tagValid <= '0;
    else if (clear_all_o) tagValid <= '0;
    else if (wr_en_o)     tagValid[wr_way_o] <= 1'b1;
  end
  assign valid_i = tagValid;

  task automatic checkOutput(input string name, input longint actual, input longint expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  function automatic longint outVec();
    return longint'({ins_ack_o, ins_way_o, wb_req_o, wb_way_o, wr_en_o, wr_way_o, wr_tag_o,
                     clear_line_o, clear_way_o, clear_all_o, flush_done_o, busy_o});
  endfunction

  function automatic void modelReset();
    for (int i = 0; i < 4; i++) begin
      refValid[i] = 1'b0;
      refDirty[i] = 1'b0;
    end
    for (int i = 0; i < 3; i++) refTree[i] = 1'b0;
  endfunction

  // refTree[0] chooses the half, refTree[1]/[2] the way inside half 0/1.
  function automatic int modelVictim();
    for (int i = 0; i < 4; i++) begin
      if (!refValid[i]) return i;
    end
    return refTree[0] ? 2 + int'(refTree[2]) : int'(refTree[1]);
  endfunction

  function automatic void modelTouch(input int w);
    refTree[0]       = (w < 2);
    refTree[1 + w/2] = (w % 2 == 0);
  endfunction

  function automatic vec_t mk(input op_e op, input int arg, input bit flag, input int delay,
                              input int expWay, input bit expWb, input int expWbCount);
    vec_t v;
    v.op = op; v.arg = arg; v.flag = flag; v.delay = delay;
    v.expWay = expWay; v.expWb = expWb; v.expWbCount = expWbCount;
    return v;
  endfunction

  // Entered and left at #1 after a rising edge with the controller idle.
  task automatic doInsert(input logic [TW-1:0] tag, input bit dty, input int wbDelay,
                          output int gotWay, output bit gotWb);
    int expWay;
    bit expWb;
    int wbCycles;
    bit acked;
    bit prevBusy;
    expWay = modelVictim();
    expWb  = refValid[expWay] && refDirty[expWay];
    ins_req_i = 1'b1; ins_tag_i = tag; ins_dirty_i = dty;
    wbCycles = 0; acked = 1'b0; prevBusy = busy_o; gotWay = -1; gotWb = 1'b0;
    for (int c = 0; c < 50 && !acked; c++) begin
      @(posedge clk_i); #1;
      wb_ack_i = 1'b0;
      if (wb_req_o) begin
        checkOutput("ins_wb_way", longint'(wb_way_o), longint'(expWay));
        wbCycles++;
        if (wbCycles == wbDelay) wb_ack_i = 1'b1;
      end
      if (ins_ack_o) begin
        acked  = 1'b1;
        gotWay = int'(ins_way_o);
        gotWb  = (wbCycles > 0);
        checkOutput("ins_way", longint'(ins_way_o), longint'(expWay));
        checkOutput("ins_wr_en", longint'(wr_en_o), 1);
        checkOutput("ins_wr_way", longint'(wr_way_o), longint'(expWay));
        checkOutput("ins_wr_tag", longint'(wr_tag_o), longint'(tag));
        checkOutput("ins_wb_needed", longint'(gotWb), longint'(expWb));
        if (expWb) checkOutput("ins_wb_hold", longint'(wbCycles), longint'(wbDelay));
        else       checkOutput("ins_ack_latency", longint'(prevBusy), 0);
        ins_req_i = 1'b0;
      end
      prevBusy = busy_o;
    end
    checkOutput("ins_ack_seen", longint'(acked), 1);
    ins_req_i = 1'b0;
    @(posedge clk_i); #1;
    refValid[expWay] = 1'b1;
    refDirty[expWay] = dty;
    modelTouch(expWay);
  endtask

  task automatic doAccess(input int way, input bit st);
    acc_en_i = 1'b1; acc_way_i = 2'(way); acc_st_i = st;
    wb_ack_i = 1'($urandom_range(0, 1));
    @(posedge clk_i); #1;
    acc_en_i = 1'b0; acc_st_i = 1'b0; wb_ack_i = 1'b0;
    checkOutput("acc_stays_idle", longint'(busy_o), 0);
    modelTouch(way);
    if (st) refDirty[way] = 1'b1;
  endtask

  // Write-backs are expected for each valid dirty way in ascending order.
  task automatic doFlush(input int delay, input bit withIns, input logic [TW-1:0] tag,
                         output int wbCount);
    int expWbs[$];
    int nExp;
    int expLat;
    int lat;
    bit done;
    int wbCycles;
    int clrCount;
    int insAcks;
    for (int i = 0; i < 4; i++) begin
      if (refValid[i] && refDirty[i]) expWbs.push_back(i);
    end
    nExp   = expWbs.size();
    expLat = 6 + nExp * delay;
    lat = 0; done = 1'b0; wbCycles = 0; clrCount = 0; insAcks = 0; wbCount = 0;
    flush_req_i = 1'b1;
    if (withIns) begin
      ins_req_i = 1'b1; ins_tag_i = tag;
    end
    for (int c = 0; c < 200 && !done; c++) begin
      @(posedge clk_i); #1;
      wb_ack_i = 1'b0;
      lat++;
      if (ins_ack_o) insAcks++;
      if (clear_all_o) clrCount++;
      if (wb_req_o) begin
        if (wbCycles == 0)
          checkOutput("flush_wb_order", longint'(wb_way_o),
                      (expWbs.size() > 0) ? longint'(expWbs[0]) : -1);
        wbCycles++;
        if (wbCycles == delay) begin
          wb_ack_i = 1'b1;
          wbCycles = 0;
          wbCount++;
          if (expWbs.size() > 0) void'(expWbs.pop_front());
        end
      end
      if (flush_done_o) begin
        done = 1'b1;
        flush_req_i = 1'b0;
      end
    end
    flush_req_i = 1'b0;
    checkOutput("flush_done_seen", longint'(done), 1);
    checkOutput("flush_latency", longint'(lat), longint'(expLat));
    checkOutput("flush_wb_count", longint'(wbCount), longint'(nExp));
    checkOutput("flush_clear_all_pulses", longint'(clrCount), 1);
    checkOutput("flush_no_ins_ack", longint'(insAcks), 0);
    if (!withIns) begin
      @(posedge clk_i); #1;
    end
    for (int i = 0; i < 4; i++) begin
      refValid[i] = 1'b0;
      refDirty[i] = 1'b0;
    end
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached before summary");
    $fatal(1);
  end

  initial begin
    vec_t vecs[$];
    int   gw;
    bit   gwb;
    int   wbc;
    int   expWay;
    bit   sawWb;
    int   ackCount;
    int   r;

    // Fill, PLRU victim after a hit, dirty eviction, then flushes.
    vecs.push_back(mk(OP_INS,   'h100, 1'b0, 1, 0, 1'b0, 0));
    vecs.push_back(mk(OP_INS,   'h101, 1'b0, 1, 1, 1'b0, 0));
    vecs.push_back(mk(OP_INS,   'h102, 1'b0, 1, 2, 1'b0, 0));
    vecs.push_back(mk(OP_INS,   'h103, 1'b0, 1, 3, 1'b0, 0));
    vecs.push_back(mk(OP_INS,   'h104, 1'b0, 1, 0, 1'b0, 0));
    vecs.push_back(mk(OP_ACC,   0,     1'b0, 0, 0, 1'b0, 0));
    vecs.push_back(mk(OP_ACC,   2,     1'b1, 0, 0, 1'b0, 0));
    vecs.push_back(mk(OP_ACC,   3,     1'b0, 0, 0, 1'b0, 0));
    vecs.push_back(mk(OP_ACC,   0,     1'b0, 0, 0, 1'b0, 0));
    vecs.push_back(mk(OP_INS,   'h105, 1'b1, 3, 2, 1'b1, 0));
    vecs.push_back(mk(OP_ACC,   1,     1'b1, 0, 0, 1'b0, 0));
    vecs.push_back(mk(OP_ACC,   3,     1'b1, 0, 0, 1'b0, 0));
    vecs.push_back(mk(OP_FLUSH, 0,     1'b0, 2, 0, 1'b0, 3));
    vecs.push_back(mk(OP_INS,   'h200, 1'b0, 1, 0, 1'b0, 0));
    vecs.push_back(mk(OP_INS,   'h201, 1'b0, 1, 1, 1'b0, 0));
    vecs.push_back(mk(OP_INS,   'h202, 1'b0, 1, 2, 1'b0, 0));
    vecs.push_back(mk(OP_INS,   'h203, 1'b0, 1, 3, 1'b0, 0));
    vecs.push_back(mk(OP_ACC,   1,     1'b1, 0, 0, 1'b0, 0));
    vecs.push_back(mk(OP_ACC,   3,     1'b1, 0, 0, 1'b0, 0));
    vecs.push_back(mk(OP_FLUSH, 0,     1'b0, 2, 0, 1'b0, 2));
    vecs.push_back(mk(OP_FLUSH, 0,     1'b0, 1, 0, 1'b0, 0));

    modelReset();
    repeat (2) @(posedge clk_i);
    #1;
    checkOutput("reset_outputs", outVec(), 0);
    @(negedge clk_i);
    rst_i = 1'b1;
    @(posedge clk_i); #1;

    foreach (vecs[k]) begin
      case (vecs[k].op)
        OP_INS: begin
          doInsert(TW'(vecs[k].arg), vecs[k].flag, vecs[k].delay, gw, gwb);
          checkOutput("tbl_ins_way", longint'(gw), longint'(vecs[k].expWay));
          checkOutput("tbl_ins_wb", longint'(gwb), longint'(vecs[k].expWb));
        end
        OP_ACC: doAccess(vecs[k].arg, vecs[k].flag);
        default: begin
          doFlush(vecs[k].delay, 1'b0, '0, wbc);
          checkOutput("tbl_flush_wbs", longint'(wbc), longint'(vecs[k].expWbCount));
        end
      endcase
    end

    // Flush and insert raised together: flush first, then insert into the cleared way 0.
    doInsert(TW'('h300), 1'b0, 1, gw, gwb);
    doInsert(TW'('h301), 1'b0, 1, gw, gwb);
    doFlush(1, 1'b1, TW'('h302), wbc);
    doInsert(TW'('h302), 1'b1, 1, gw, gwb);
    checkOutput("flush_then_ins_way", longint'(gw), 0);

    // Reset in the middle of an eviction write-back.
    doInsert(TW'('h303), 1'b1, 1, gw, gwb);
    doInsert(TW'('h304), 1'b1, 1, gw, gwb);
    doInsert(TW'('h305), 1'b1, 1, gw, gwb);
    expWay = modelVictim();
    ins_req_i = 1'b1; ins_tag_i = TW'('h3ff); ins_dirty_i = 1'b0;
    sawWb = 1'b0;
    for (int c = 0; c < 10 && !sawWb; c++) begin
      @(posedge clk_i); #1;
      if (wb_req_o) sawWb = 1'b1;
    end
    checkOutput("rst_pre_wb", longint'(sawWb), 1);
    checkOutput("rst_pre_wb_way", longint'(wb_way_o), longint'(expWay));
    #2;
    rst_i = 1'b0;
    ins_req_i = 1'b0;
    #1;
    checkOutput("rst_async_outputs", outVec(), 0);
    modelReset();
    @(negedge clk_i);
    @(negedge clk_i);
    rst_i = 1'b1;
    ackCount = 0;
    for (int c = 0; c < 4; c++) begin
      @(posedge clk_i); #1;
      if (ins_ack_o || wr_en_o || wb_req_o) ackCount++;
    end
    checkOutput("rst_no_ack", longint'(ackCount), 0);
    doInsert(TW'('h400), 1'b0, 1, gw, gwb);
    checkOutput("post_rst_ins_way", longint'(gw), 0);

    for (int n = 0; n < 250; n++) begin
      r = int'($urandom_range(0, 9));
      if (r < 6)
        doInsert(TW'($urandom()), 1'($urandom_range(0, 1)), int'($urandom_range(1, 3)), gw, gwb);
      else if (r < 9)
        doAccess(int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
      else
        doFlush(int'($urandom_range(1, 2)), 1'b0, '0, wbc);
    end

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
